// File: rtl/mul32_pkg.sv
// Shared arithmetic-unit definitions for the sequential multiplier and divider.
// Iteration count and IDLE/RUN encoding are common to both controllers.
package mul32_pkg;

  localparam int ARITH_W     = 32;
  localparam int ARITH_ITERS = 32;
  localparam int ARITH_CNT_W = 6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } arith_state_e;

endpackage

// File: rtl/mul32_cla.sv
// 33-bit carry-lookahead adder: eight 4-bit lookahead groups plus a top bit.
// sub_flag inverts b and injects a carry-in for two's-complement subtract.
module cla_33 (
  input  logic [32:0] a,
  input  logic [32:0] b,
  input  logic        sub_flag,
  output logic [32:0] sum,
  output logic        carry_out
);

  logic [32:0] b_eff;
  logic [32:0] g;
  logic [32:0] p;
  logic [32:0] c;
  logic [8:0]  bc;

  assign b_eff = b ^ {33{sub_flag}};
  assign g     = a & b_eff;
  assign p     = a ^ b_eff;

  always_comb begin
    bc    = '0;
    c     = '0;
    bc[0] = sub_flag;
    for (int j = 0; j < 8; j++) begin
      // group generate/propagate feed the next group's carry-in
      bc[j+1] = g[4*j+3]
              | (p[4*j+3] & g[4*j+2])
              | (p[4*j+3] & p[4*j+2] & g[4*j+1])
              | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j])
              | (&p[4*j +: 4] & bc[j]);
      c[4*j]   = bc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & bc[j]);
      c[4*j+2] = g[4*j+1]
               | (p[4*j+1] & g[4*j])
               | (p[4*j+1] & p[4*j] & bc[j]);
      c[4*j+3] = g[4*j+2]
               | (p[4*j+2] & g[4*j+1])
               | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & bc[j]);
    end
    c[32] = bc[8];
  end

  assign sum       = p ^ c;
  assign carry_out = g[32] | (p[32] & c[32]);

endmodule

// File: rtl/mul32.sv
// Sequential 32x32 unsigned shift-add multiplier, one iteration per clock.
// {carry,A,Q} shifts right each step; product is {A,Q} after 32 steps.
import mul32_pkg::*;

module mul32 #(
  parameter int WIDTH = ARITH_W,
  parameter int CNT_W = ARITH_CNT_W
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo,
  output logic             busy,
  output logic             done
);

  if (WIDTH != ARITH_W) begin : g_bad_width
    $error("mul32: WIDTH must be 32, adder is fixed at 33 bits");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ARITH_ITERS - 1);

  arith_state_e     state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] addend;
  logic [ARITH_W:0] sum;
  logic             carry_unused;

  assign addend = q_q[0] ? m_q : '0;

  cla_33 u_cla (
    .a         ({1'b0, a_q}),
    .b         ({1'b0, addend}),
    .sub_flag  (1'b0),
    .sum       (sum),
    .carry_out (carry_unused)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
      a_q   <= '0;
      q_q   <= '0;
      m_q   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            m_q   <= src2;
            a_q   <= '0;
            q_q   <= src1;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_q <= sum[ARITH_W:1];
          q_q <= {sum[0], q_q[WIDTH-1:1]};
          if (cnt == LAST) begin
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign prod_hi = a_q;
  assign prod_lo = q_q;

endmodule

// File: tb/tb_mul32.sv
// Directed bench for mul32: latency, products, handshake corner cases.
// Expected values are hand-computed constants.
module tb_mul32;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        start;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] prod_hi;
  logic [31:0] prod_lo;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  mul32 dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .start   (start),
    .src1    (src1),
    .src2    (src2),
    .prod_hi (prod_hi),
    .prod_lo (prod_lo),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 64) begin
      tick();
      cyc++;
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    src1  = a;
    src2  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_op(input string tag,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [63:0] exp);
    int cyc;
    issue(a, b);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(cyc);
    chk({tag, "_lat"}, 64'(cyc), 64'd32);
    chk({tag, "_prod"}, {prod_hi, prod_lo}, exp);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    tick();
    chk({tag, "_pulse"}, 64'(done), 64'd0);
    chk({tag, "_hold"}, {prod_hi, prod_lo}, exp);
  endtask

  initial begin
    int cyc;
    int ndone;
    n_rst = 1'b0;
    start = 1'b0;
    src1  = '0;
    src2  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", 64'(prod_hi), 64'd0);
    chk("rst_lo", 64'(prod_lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    n_rst = 1'b1;
    tick();

    run_op("7x6", 32'd7, 32'd6, 64'h0000_0000_0000_002A);
    run_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           64'hFFFF_FFFE_0000_0001);
    run_op("msb", 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000);
    run_op("zero", 32'd0, 32'h1234_5678, 64'd0);
    run_op("zero_m", 32'h1234_5678, 32'd0, 64'd0);

    // start while busy must be ignored
    issue(32'd3, 32'd5);
    repeat (9) tick();
    src1  = 32'd9;
    src2  = 32'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_busy", 64'(busy), 64'd1);
    wait_done(cyc);
    chk("ign_lat", 64'(cyc + 10), 64'd32);
    chk("ign_prod", {prod_hi, prod_lo}, 64'd15);
    ndone = 0;
    repeat (40) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    chk("ign_extra_done", 64'(ndone), 64'd0);
    chk("ign_idle", 64'(busy), 64'd0);

    // back-to-back: start on the done cycle
    issue(32'd2, 32'd3);
    wait_done(cyc);
    chk("b2b_first", {prod_hi, prod_lo}, 64'd6);
    src1  = 32'h0001_0000;
    src2  = 32'h0001_0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b_done_drop", 64'(done), 64'd0);
    chk("b2b_busy", 64'(busy), 64'd1);
    wait_done(cyc);
    chk("b2b_lat", 64'(cyc + 1), 64'd33);
    chk("b2b_prod", {prod_hi, prod_lo}, 64'h0000_0001_0000_0000);
    tick();

    // asynchronous reset mid-operation
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (14) tick();
    #2;
    n_rst = 1'b0;
    #1;
    chk("arst_prod", {prod_hi, prod_lo}, 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    @(posedge clk);
    #3;
    n_rst = 1'b1;
    ndone = 0;
    repeat (40) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    chk("arst_no_done", 64'(ndone), 64'd0);
    chk("arst_idle", 64'(busy), 64'd0);
    run_op("post_rst", 32'd7, 32'd6, 64'd42);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
